adc_scan_seq: RTL and testbench



---
 rtl/adc_scan_seq.sv | 201 ++++++++++++++++++++
 tb/tb_adc_scan_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_seq.sv
// Multi-channel ADC scan sequencer: walks a channel list, drops settling conversions,
// averages each slot and publishes one double-buffered frame per scan with valid/ready.
module adc_scan_seq #(
    parameter int               NCH      = 2,
    parameter int               DW       = 12,
    parameter logic [NCH*3-1:0] CH_LIST  = {3'b100, 3'b110},
    parameter int               AVG_LOG2 = 0,
    parameter int               DISCARD  = 1
) (
    input  logic                ADC_CLK,
    input  logic                RST,
    input  logic                en,
    input  logic                mode,
    input  logic                start,
    input  logic                adc_eoc,
    input  logic [DW-1:0]       adc_dout,
    output logic [2:0]          adc_s,
    output logic                adc_soc,
    output logic [NCH*DW-1:0]   frame_data,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                overrun,
    input  logic                clr_ovr,
    output logic                busy
);

    localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSLOT = 1 << SW;
    localparam int AW    = DW + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;

    localparam logic [CW-1:0] SMP_LAST  = CW'((1 << AVG_LOG2) - 1);
    localparam logic [1:0]    DISC_INIT = 2'(DISCARD);
    localparam logic [1:0]    DISC_WRAP = (NCH > 1) ? 2'(DISCARD) : 2'd0;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [SW-1:0]     slot_reg, slot_next;
    logic [1:0]        disc_cnt_reg, disc_cnt_next;
    logic [AW-1:0]     acc_reg, acc_next;
    logic [CW-1:0]     smp_cnt_reg, smp_cnt_next;
    logic [2:0]        adc_s_reg, adc_s_next;
    logic              eoc_d_reg;
    logic [DW-1:0]     work_reg [NCH];
    logic [NCH*DW-1:0] frame_data_reg;
    logic              frame_valid_reg;
    logic              overrun_reg;

    logic              eoc_rise;
    logic              slot_done;
    logic              publish;
    logic [SW-1:0]     slot_inc;
    logic [AW-1:0]     sum;
    logic [DW-1:0]     avg;
    logic [2:0]        ch_code [NSLOT];
    logic [NCH*DW-1:0] frame_next;

    assign eoc_rise = adc_eoc & ~eoc_d_reg;
    assign slot_inc = slot_reg + 1'b1;
    assign sum      = acc_reg + AW'(adc_dout);
    assign avg      = sum[AW-1:AVG_LOG2];

    // Table padded to a power of two so a slot index can never fall off the end.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_code
            if (gi < NCH) begin : g_used
                assign ch_code[gi] = CH_LIST[3*gi +: 3];
            end else begin : g_pad
                assign ch_code[gi] = CH_LIST[2:0];
            end
        end
    endgenerate

    // The slot finishing this cycle is folded in directly so the frame is captured whole.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_frame
            assign frame_next[gi*DW +: DW] = (slot_reg == SW'(gi)) ? avg : work_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        slot_next     = slot_reg;
        disc_cnt_next = disc_cnt_reg;
        acc_next      = acc_reg;
        smp_cnt_next  = smp_cnt_reg;
        adc_s_next    = adc_s_reg;
        slot_done     = 1'b0;
        publish       = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((!mode && en) || (mode && start)) begin
                    state_next    = SCAN;
                    slot_next     = '0;
                    adc_s_next    = ch_code[0];
                    disc_cnt_next = DISC_INIT;
                    acc_next      = '0;
                    smp_cnt_next  = '0;
                end
            end
            SCAN: begin
                if (eoc_rise) begin
                    if (disc_cnt_reg != 2'd0) begin
                        disc_cnt_next = disc_cnt_reg - 2'd1;
                    end else if (smp_cnt_reg == SMP_LAST) begin
                        slot_done    = 1'b1;
                        acc_next     = '0;
                        smp_cnt_next = '0;
                        if (slot_reg == LAST_SLOT) begin
                            publish       = 1'b1;
                            slot_next     = '0;
                            adc_s_next    = ch_code[0];
                            disc_cnt_next = DISC_WRAP;
                            if (mode || !en) begin
                                state_next = IDLE;
                            end
                        end else begin
                            slot_next     = slot_inc;
                            adc_s_next    = ch_code[slot_inc];
                            disc_cnt_next = DISC_INIT;
                        end
                    end else begin
                        acc_next     = sum;
                        smp_cnt_next = smp_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            slot_reg     <= '0;
            disc_cnt_reg <= '0;
            acc_reg      <= '0;
            smp_cnt_reg  <= '0;
            adc_s_reg    <= ch_code[0];
            eoc_d_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_reg     <= slot_next;
            disc_cnt_reg <= disc_cnt_next;
            acc_reg      <= acc_next;
            smp_cnt_reg  <= smp_cnt_next;
            adc_s_reg    <= adc_s_next;
            eoc_d_reg    <= adc_eoc;
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                work_reg[i] <= '0;
            end
        end else if (slot_done) begin
            for (int i = 0; i < NCH; i++) begin
                if (slot_reg == SW'(i)) begin
                    work_reg[i] <= avg;
                end
            end
        end
    end

    // A new frame always wins; overrun marks that an unread frame was replaced.
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            frame_data_reg  <= '0;
            frame_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (publish) begin
                frame_data_reg <= frame_next;
            end
            if (publish) begin
                frame_valid_reg <= 1'b1;
            end else if (frame_valid_reg && frame_ready) begin
                frame_valid_reg <= 1'b0;
            end
            if (publish && frame_valid_reg && !frame_ready) begin
                overrun_reg <= 1'b1;
            end else if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign adc_s       = adc_s_reg;
    assign adc_soc     = (state_reg == SCAN);
    assign busy        = (state_reg == SCAN);
    assign frame_data  = frame_data_reg;
    assign frame_valid = frame_valid_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed bench for adc_scan_seq: default I/Q scan with handshake, averaging
// single-channel build, and four-channel single-shot build.
module tb_adc_scan_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults, continuous
    logic        en_a = 1'b0, start_a = 1'b0, eoc_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
    logic [11:0] dout_a = '0;
    logic [2:0]  s_a;
    logic        soc_a, valid_a, ovr_a, busy_a;
    logic [23:0] fd_a;

    // Instance B: NCH=1, AVG_LOG2=2, DISCARD=0
    logic        en_b = 1'b0, eoc_b = 1'b0;
    logic [11:0] dout_b = '0;
    logic [2:0]  s_b;
    logic        soc_b, valid_b, ovr_b, busy_b;
    logic [11:0] fd_b;

    // Instance C: NCH=4 single-shot
    logic        start_c = 1'b0, eoc_c = 1'b0;
    logic [11:0] dout_c = '0;
    logic [2:0]  s_c;
    logic        soc_c, valid_c, ovr_c, busy_c;
    logic [47:0] fd_c;

    adc_scan_seq u_a (
        .ADC_CLK(clk), .RST(rst), .en(en_a), .mode(1'b0), .start(start_a),
        .adc_eoc(eoc_a), .adc_dout(dout_a), .adc_s(s_a), .adc_soc(soc_a),
        .frame_data(fd_a), .frame_valid(valid_a), .frame_ready(ready_a),
        .overrun(ovr_a), .clr_ovr(clr_a), .busy(busy_a)
    );

    adc_scan_seq #(.NCH(1), .DW(12), .CH_LIST(3'b101), .AVG_LOG2(2), .DISCARD(0)) u_b (
        .ADC_CLK(clk), .RST(rst), .en(en_b), .mode(1'b0), .start(1'b0),
        .adc_eoc(eoc_b), .adc_dout(dout_b), .adc_s(s_b), .adc_soc(soc_b),
        .frame_data(fd_b), .frame_valid(valid_b), .frame_ready(1'b0),
        .overrun(ovr_b), .clr_ovr(1'b0), .busy(busy_b)
    );

    adc_scan_seq #(.NCH(4), .DW(12), .CH_LIST({3'd0, 3'd1, 3'd3, 3'd4}), .AVG_LOG2(0), .DISCARD(1)) u_c (
        .ADC_CLK(clk), .RST(rst), .en(1'b0), .mode(1'b1), .start(start_c),
        .adc_eoc(eoc_c), .adc_dout(dout_c), .adc_s(s_c), .adc_soc(soc_c),
        .frame_data(fd_c), .frame_valid(valid_c), .frame_ready(1'b0),
        .overrun(ovr_c), .clr_ovr(1'b0), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [11:0] d);
        dout_a = d; eoc_a = 1'b1; step(); eoc_a = 1'b0; step();
    endtask

    task automatic pulse_b(input logic [11:0] d);
        dout_b = d; eoc_b = 1'b1; step(); eoc_b = 1'b0; step();
    endtask

    task automatic pulse_c(input logic [11:0] d);
        dout_c = d; eoc_c = 1'b1; step(); eoc_c = 1'b0; step();
    endtask

    initial begin
        repeat (3) step();
        check("rst_a_s",     64'(s_a), 64'h6);
        check("rst_a_soc",   64'(soc_a), 64'h0);
        check("rst_a_busy",  64'(busy_a), 64'h0);
        check("rst_a_data",  64'(fd_a), 64'h0);
        check("rst_a_valid", 64'(valid_a), 64'h0);
        check("rst_a_ovr",   64'(ovr_a), 64'h0);
        check("rst_b_s",     64'(s_b), 64'h5);
        check("rst_c_s",     64'(s_c), 64'h4);
        rst = 1'b0;
        step();
        check("idle_a_soc",  64'(soc_a), 64'h0);

        // Default continuous scan
        en_a = 1'b1; step();
        check("a_busy_up",   64'(busy_a), 64'h1);
        check("a_soc_up",    64'(soc_a), 64'h1);
        pulse_a(12'hFFF);
        check("a_s_disc",    64'(s_a), 64'h6);
        pulse_a(12'h111);
        check("a_s_slot1",   64'(s_a), 64'h4);
        check("a_valid_mid", 64'(valid_a), 64'h0);
        pulse_a(12'hFFF);
        pulse_a(12'h222);
        check("a_f1_data",   64'(fd_a), 64'h222111);
        check("a_f1_valid",  64'(valid_a), 64'h1);
        check("a_f1_s",      64'(s_a), 64'h6);
        check("a_f1_ovr",    64'(ovr_a), 64'h0);

        // Second frame unread -> overrun, newest data wins
        pulse_a(12'hFFF); pulse_a(12'h333); pulse_a(12'hFFF); pulse_a(12'h444);
        check("a_f2_data",   64'(fd_a), 64'h444333);
        check("a_f2_ovr",    64'(ovr_a), 64'h1);
        check("a_f2_valid",  64'(valid_a), 64'h1);
        ready_a = 1'b1; clr_a = 1'b1; step(); ready_a = 1'b0; clr_a = 1'b0;
        check("a_acc_valid", 64'(valid_a), 64'h0);
        check("a_clr_ovr",   64'(ovr_a), 64'h0);

        pulse_a(12'hFFF); pulse_a(12'h555); pulse_a(12'hFFF); pulse_a(12'h666);
        check("a_f3_data",   64'(fd_a), 64'h666555);
        check("a_f3_ovr",    64'(ovr_a), 64'h0);

        // Overrun set beats a coincident clear
        pulse_a(12'hFFF); pulse_a(12'h777); pulse_a(12'hFFF);
        dout_a = 12'h888; eoc_a = 1'b1; clr_a = 1'b1; step(); eoc_a = 1'b0; clr_a = 1'b0; step();
        check("a_f4_data",   64'(fd_a), 64'h888777);
        check("a_f4_ovr",    64'(ovr_a), 64'h1);
        clr_a = 1'b1; step(); clr_a = 1'b0;
        check("a_clr2_ovr",  64'(ovr_a), 64'h0);
        check("a_clr2_vld",  64'(valid_a), 64'h1);

        // Publish coincident with acceptance: valid stays, no overrun
        pulse_a(12'hFFF); pulse_a(12'h999); pulse_a(12'hFFF);
        dout_a = 12'hAAA; eoc_a = 1'b1; ready_a = 1'b1; step(); eoc_a = 1'b0; ready_a = 1'b0; step();
        check("a_f5_data",   64'(fd_a), 64'hAAA999);
        check("a_f5_valid",  64'(valid_a), 64'h1);
        check("a_f5_ovr",    64'(ovr_a), 64'h0);
        ready_a = 1'b1; step(); ready_a = 1'b0;

        // en dropped mid-slot1: frame still completes, then idle
        pulse_a(12'hFFF); pulse_a(12'h0AA);
        en_a = 1'b0;
        pulse_a(12'hFFF);
        check("a_en_busy",   64'(busy_a), 64'h1);
        pulse_a(12'h0BB);
        check("a_f6_data",   64'(fd_a), 64'h0BB0AA);
        check("a_f6_valid",  64'(valid_a), 64'h1);
        check("a_f6_busy",   64'(busy_a), 64'h0);
        check("a_f6_soc",    64'(soc_a), 64'h0);
        pulse_a(12'h123); pulse_a(12'h123);
        check("a_idle_data", 64'(fd_a), 64'h0BB0AA);

        // Averaging, single channel
        en_b = 1'b1; step();
        pulse_b(12'd10); pulse_b(12'd11); pulse_b(12'd12);
        check("b_valid_mid", 64'(valid_b), 64'h0);
        pulse_b(12'd14);
        check("b_avg",       64'(fd_b), 64'd11);
        check("b_valid",     64'(valid_b), 64'h1);
        check("b_s",         64'(s_b), 64'h5);
        repeat (4) pulse_b(12'hFFF);
        check("b_avg_max",   64'(fd_b), 64'hFFF);
        check("b_ovr",       64'(ovr_b), 64'h1);
        en_b = 1'b0;

        // Four-channel single-shot
        start_c = 1'b1; step(); start_c = 1'b0;
        check("c_busy_up",   64'(busy_c), 64'h1);
        check("c_s0",        64'(s_c), 64'h4);
        pulse_c(12'hFFF); pulse_c(12'h100);
        check("c_s1",        64'(s_c), 64'h3);
        pulse_c(12'hFFF); pulse_c(12'h101);
        check("c_s2",        64'(s_c), 64'h1);
        start_c = 1'b1; step(); start_c = 1'b0;
        check("c_start_ign", 64'(s_c), 64'h1);
        pulse_c(12'hFFF); pulse_c(12'h102);
        check("c_s3",        64'(s_c), 64'h0);
        check("c_valid_mid", 64'(valid_c), 64'h0);
        pulse_c(12'hFFF); pulse_c(12'h103);
        check("c_data",      64'(fd_c), 64'h103102101100);
        check("c_valid",     64'(valid_c), 64'h1);
        check("c_busy_dn",   64'(busy_c), 64'h0);
        pulse_c(12'h555); pulse_c(12'h555);
        check("c_idle_data", 64'(fd_c), 64'h103102101100);
        check("c_idle_ovr",  64'(ovr_c), 64'h0);

        // Reset mid-scan with adc_eoc held high across release
        en_a = 1'b1; step();
        pulse_a(12'hFFF); pulse_a(12'h111);
        check("a_pre_rst_s", 64'(s_a), 64'h4);
        rst = 1'b1; dout_a = 12'hFFF; eoc_a = 1'b1; step();
        check("mrst_s",      64'(s_a), 64'h6);
        check("mrst_soc",    64'(soc_a), 64'h0);
        check("mrst_busy",   64'(busy_a), 64'h0);
        check("mrst_data",   64'(fd_a), 64'h0);
        check("mrst_valid",  64'(valid_a), 64'h0);
        check("mrst_ovr",    64'(ovr_a), 64'h0);
        step();
        rst = 1'b0; step(); step(); step();
        check("held_busy",   64'(busy_a), 64'h1);
        check("held_s",      64'(s_a), 64'h6);
        eoc_a = 1'b0; step();
        pulse_a(12'hFFF); pulse_a(12'h777);
        check("rs_s1",       64'(s_a), 64'h4);
        pulse_a(12'hFFF); pulse_a(12'h888);
        check("rs_data",     64'(fd_a), 64'h888777);
        check("rs_valid",    64'(valid_a), 64'h1);
        check("rs_ovr",      64'(ovr_a), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
